// File: rtl/extremum_finder_pkg.sv
// Shared types and helpers for the multi-channel windowed extremum finder.
package extremum_finder_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } ef_state_t;

    localparam int OVR_WIDTH = 16;

    function automatic logic [OVR_WIDTH-1:0] sat_inc(input logic [OVR_WIDTH-1:0] value);
        if (value == {OVR_WIDTH{1'b1}}) begin
            return value;
        end else begin
            return value + {{(OVR_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/ef_channel.sv
// Per-channel max/min tracker; presents the shifted final extremes on the last beat of a window.
module ef_channel #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] sample,
    input  logic                         beat_en,
    input  logic                         first_beat,
    input  logic                         last_beat,
    input  logic [2:0]                   shift,
    output logic signed [DATA_WIDTH-1:0] max_shifted,
    output logic signed [DATA_WIDTH-1:0] min_shifted,
    output logic                         load
);

    logic signed [DATA_WIDTH-1:0] max_r, min_r;
    logic signed [DATA_WIDTH-1:0] max_next_s, min_next_s;

    // Next extremes include the current sample so the last beat is part of the result.
    always_comb begin
        max_next_s = max_r;
        min_next_s = min_r;
        if (first_beat) begin
            max_next_s = sample;
            min_next_s = sample;
        end else begin
            if (sample > max_r) begin
                max_next_s = sample;
            end else begin
                max_next_s = max_r;
            end
            if (sample < min_r) begin
                min_next_s = sample;
            end else begin
                min_next_s = min_r;
            end
        end
        max_shifted = max_next_s >>> shift;
        min_shifted = min_next_s >>> shift;
        load        = beat_en & last_beat;
    end

    // Tracker registers advance only on accepted beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_r <= '0;
            min_r <= '0;
        end else if (beat_en) begin
            max_r <= max_next_s;
            min_r <= min_next_s;
        end else begin
            max_r <= max_r;
            min_r <= min_r;
        end
    end

endmodule

// File: rtl/extremum_finder_mc.sv
// Windowed multi-channel min/max detector: FSM, beat counter, reconfiguration restart,
// AXI-Stream result register and saturating overrun counter.
module extremum_finder_mc
    import extremum_finder_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_CH        = 2,
    parameter int MAX_LOG_COUNT = 20
) (
    input  logic                           SYS_aclk,
    input  logic                           SYS_aresetn,
    input  logic [4:0]                     EF_log_count,
    input  logic [2:0]                     EF_shift,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   S_AXIS_tdata,
    input  logic                           S_AXIS_tvalid,
    output logic                           S_AXIS_tready,
    output logic [2*NUM_CH*DATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                           M_AXIS_tvalid,
    input  logic                           M_AXIS_tready,
    output logic [OVR_WIDTH-1:0]           EF_overrun_count
);

    ef_state_t                      state_r, state_next_s;
    logic [MAX_LOG_COUNT-1:0]       cnt_r, cnt_next_s, last_idx_s;
    logic [4:0]                     log_prev_r, eff_log_s, shamt_s;
    logic                           beat_en_s, first_beat_s, last_beat_s, log_changed_s;
    logic [NUM_CH-1:0]              load_s;
    logic                           result_load_s;
    logic [2*NUM_CH*DATA_WIDTH-1:0] result_s, tdata_r;
    logic                           tvalid_r;
    logic [OVR_WIDTH-1:0]           ovr_r;

    assign S_AXIS_tready    = 1'b1;
    assign M_AXIS_tdata     = tdata_r;
    assign M_AXIS_tvalid    = tvalid_r;
    assign EF_overrun_count = ovr_r;

    // Window control: a reconfiguration in ACCUM clears the counter and drops that cycle's beat.
    always_comb begin
        eff_log_s     = (EF_log_count > 5'(MAX_LOG_COUNT)) ? 5'(MAX_LOG_COUNT) : EF_log_count;
        shamt_s       = 5'(MAX_LOG_COUNT) - eff_log_s;
        last_idx_s    = {MAX_LOG_COUNT{1'b1}} >> shamt_s;
        log_changed_s = (EF_log_count != log_prev_r);
        first_beat_s  = (cnt_r == '0);
        last_beat_s   = (cnt_r == last_idx_s);
        beat_en_s     = 1'b0;
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        case (state_r)
            IDLE: begin
                cnt_next_s = '0;
                if (EF_log_count != 5'd0) begin
                    state_next_s = ACCUM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCUM: begin
                if (EF_log_count == 5'd0) begin
                    state_next_s = IDLE;
                    cnt_next_s   = '0;
                end else if (log_changed_s) begin
                    cnt_next_s = '0;
                end else if (S_AXIS_tvalid) begin
                    beat_en_s  = 1'b1;
                    cnt_next_s = last_beat_s ? '0 : cnt_r + {{(MAX_LOG_COUNT-1){1'b0}}, 1'b1};
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // FSM, counter and the previous configuration for change detection.
    always_ff @(posedge SYS_aclk) begin
        if (!SYS_aresetn) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            log_prev_r <= 5'd0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            log_prev_r <= EF_log_count;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DATA_WIDTH-1:0] ch_max_s, ch_min_s;

        ef_channel #(.DATA_WIDTH(DATA_WIDTH)) u_ch (
            .clk         (SYS_aclk),
            .rst_n       (SYS_aresetn),
            .sample      (S_AXIS_tdata[g*DATA_WIDTH +: DATA_WIDTH]),
            .beat_en     (beat_en_s),
            .first_beat  (first_beat_s),
            .last_beat   (last_beat_s),
            .shift       (EF_shift),
            .max_shifted (ch_max_s),
            .min_shifted (ch_min_s),
            .load        (load_s[g])
        );

        assign result_s[g*2*DATA_WIDTH +: 2*DATA_WIDTH] = {ch_min_s, ch_max_s};
    end

    assign result_load_s = &load_s;

    // Output register: a new result wins over a handshake; overwriting unaccepted data is an overrun.
    always_ff @(posedge SYS_aclk) begin
        if (!SYS_aresetn) begin
            tdata_r  <= '0;
            tvalid_r <= 1'b0;
            ovr_r    <= '0;
        end else if (result_load_s) begin
            tdata_r  <= result_s;
            tvalid_r <= 1'b1;
            if (tvalid_r && !M_AXIS_tready) begin
                ovr_r <= sat_inc(ovr_r);
            end else begin
                ovr_r <= ovr_r;
            end
        end else if (tvalid_r && M_AXIS_tready) begin
            tvalid_r <= 1'b0;
        end else begin
            tvalid_r <= tvalid_r;
        end
    end

endmodule

// File: tb/tb_extremum_finder_mc.sv
// Directed plus randomized bench for extremum_finder_mc against a queue-based window model.
module tb_extremum_finder_mc;

    localparam int DW  = 32;
    localparam int NC  = 2;
    localparam int MLC = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic [4:0]       log_cnt;
    logic [2:0]       shift;
    logic [NC*DW-1:0] s_tdata;
    logic             s_tvalid, s_tready;
    logic [2*NC*DW-1:0] m_tdata;
    logic             m_tvalid, m_tready;
    logic [15:0]      ovr;

    always #5 clk = ~clk;

    extremum_finder_mc #(.DATA_WIDTH(DW), .NUM_CH(NC), .MAX_LOG_COUNT(MLC)) dut (
        .SYS_aclk         (clk),
        .SYS_aresetn      (rstn),
        .EF_log_count     (log_cnt),
        .EF_shift         (shift),
        .S_AXIS_tdata     (s_tdata),
        .S_AXIS_tvalid    (s_tvalid),
        .S_AXIS_tready    (s_tready),
        .M_AXIS_tdata     (m_tdata),
        .M_AXIS_tvalid    (m_tvalid),
        .M_AXIS_tready    (m_tready),
        .EF_overrun_count (ovr)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int                 q0[$];
    int                 q1[$];
    logic [2*NC*DW-1:0] e_data  = '0;
    bit                 e_valid = 1'b0;
    int                 e_ovr   = 0;
    bit                 e_active = 1'b0;
    logic [4:0]         e_prev  = 5'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*DW-1:0] slot(input int q[$], input int sh);
        int mn = q[0];
        int mx = q[0];
        foreach (q[i]) begin
            if (q[i] < mn) mn = q[i];
            if (q[i] > mx) mx = q[i];
        end
        return {32'(mn >>> sh), 32'(mx >>> sh)};
    endfunction

    task automatic model_step();
        bit                 changed;
        bit                 loaded;
        int                 n;
        logic [2*NC*DW-1:0] nd;
        if (!rstn) begin
            q0.delete(); q1.delete();
            e_data = '0; e_valid = 1'b0; e_ovr = 0; e_active = 1'b0; e_prev = 5'd0;
            return;
        end
        changed = (log_cnt != e_prev);
        loaded  = 1'b0;
        nd      = '0;
        n       = 1 << ((int'(log_cnt) > MLC) ? MLC : int'(log_cnt));
        if (e_active && log_cnt != 5'd0 && !changed && s_tvalid) begin
            q0.push_back(int'($signed(s_tdata[DW-1:0])));
            q1.push_back(int'($signed(s_tdata[2*DW-1:DW])));
            if (q0.size() == n) begin
                nd[63:0]   = slot(q0, int'(shift));
                nd[127:64] = slot(q1, int'(shift));
                loaded = 1'b1;
                q0.delete(); q1.delete();
            end
        end
        if (changed || log_cnt == 5'd0) begin
            q0.delete(); q1.delete();
        end
        if (loaded) begin
            if (e_valid && !m_tready && e_ovr < 65535) e_ovr++;
            e_valid = 1'b1;
            e_data  = nd;
        end else if (e_valid && m_tready) begin
            e_valid = 1'b0;
        end
        e_active = (log_cnt != 5'd0);
        e_prev   = log_cnt;
    endtask

    task automatic check_all();
        chk("tready", {31'd0, s_tready}, 32'd1);
        chk("tvalid", {31'd0, m_tvalid}, {31'd0, e_valid});
        chk("overrun", {16'd0, ovr}, 32'(e_ovr));
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("max_ch%0d", c), m_tdata[c*64 +: 32], e_data[c*64 +: 32]);
            chk($sformatf("min_ch%0d", c), m_tdata[c*64+32 +: 32], e_data[c*64+32 +: 32]);
        end
    endtask

    task automatic cyc(input bit v, input int d0, input int d1);
        s_tvalid = v;
        s_tdata  = {32'(d1), 32'(d0)};
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic chk_ch0(input string tag, input int mn, input int mx);
        chk({tag, "_valid"}, {31'd0, m_tvalid}, 32'd1);
        chk({tag, "_min"}, m_tdata[63:32], 32'(mn));
        chk({tag, "_max"}, m_tdata[31:0], 32'(mx));
    endtask

    int basic[8] = '{-10, -30, -40, -20, 10, 20, 30, 40};

    initial begin
        rstn = 1'b0; log_cnt = 5'd0; shift = 3'd0; m_tready = 1'b1;
        s_tvalid = 1'b0; s_tdata = '0;
        cyc(0, 0, 0); cyc(0, 0, 0);
        chk("reset_valid", {31'd0, m_tvalid}, 32'd0);
        chk("reset_data", m_tdata[31:0] | m_tdata[63:32] | m_tdata[95:64] | m_tdata[127:96], 32'd0);
        rstn = 1'b1;

        // idle: no output
        for (int i = 0; i < 5; i++) cyc(1, i + 3, -i);
        chk("idle_valid", {31'd0, m_tvalid}, 32'd0);

        // basic window
        log_cnt = 5'd3; cyc(0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, basic[i], -basic[i]);
        chk_ch0("basic", -40, 40);
        chk("basic_ch1_min", m_tdata[127:96], 32'(-40));
        chk("basic_ch1_max", m_tdata[95:64], 32'd40);

        // shift 2 then 7, back-to-back windows
        shift = 3'd2;
        for (int i = 0; i < 8; i++) cyc(1, basic[i], -basic[i]);
        chk_ch0("shift2", -10, 10);
        shift = 3'd7;
        for (int i = 0; i < 8; i++) cyc(1, basic[i], -basic[i]);
        chk_ch0("shift7", -1, 0);
        shift = 3'd0;

        // idle then restart
        log_cnt = 5'd0;
        for (int i = 0; i < 5; i++) cyc(1, 77, 77);
        log_cnt = 5'd2; cyc(0, 0, 0);
        cyc(1, 5, 0); cyc(1, 1, 0); cyc(1, 9, 0); cyc(1, 3, 0);
        chk_ch0("log2", 1, 9);
        cyc(1, 100, 0); cyc(1, -100, 0);
        log_cnt = 5'd3; cyc(0, 0, 0);
        for (int i = 1; i <= 8; i++) cyc(1, i, 0);
        chk_ch0("restart", 1, 8);

        // gaps
        log_cnt = 5'd2; cyc(0, 0, 0);
        cyc(1, 4, 0); cyc(1, 7, 0);
        cyc(0, -99, 0); cyc(0, 99, 0); cyc(0, 0, 0);
        cyc(1, 2, 0);
        chk("gap_early", {31'd0, m_tvalid}, 32'd0);
        cyc(1, 6, 0);
        chk_ch0("gap", 2, 7);

        // backpressure and overrun
        log_cnt = 5'd1; cyc(0, 0, 0);
        m_tready = 1'b0;
        for (int i = 1; i <= 6; i++) cyc(1, i, 0);
        chk("ovr_three", {16'd0, ovr}, 32'd2);
        chk_ch0("ovr_data", 5, 6);
        cyc(1, 7, 0);
        m_tready = 1'b1;
        cyc(1, 8, 0);
        chk("ovr_pulse", {16'd0, ovr}, 32'd2);
        chk_ch0("ovr_new", 7, 8);
        cyc(0, 0, 0);
        chk("ovr_drain", {31'd0, m_tvalid}, 32'd0);

        // reset mid-window
        log_cnt = 5'd3; cyc(0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1000, -1000);
        rstn = 1'b0; cyc(0, 0, 0);
        chk("rst_ovr", {16'd0, ovr}, 32'd0);
        chk("rst_data", m_tdata[31:0] | m_tdata[63:32], 32'd0);
        rstn = 1'b1; cyc(0, 0, 0);
        for (int i = -3; i <= 4; i++) cyc(1, i, 0);
        chk_ch0("post_rst", -3, 4);

        // clamped window length
        log_cnt = 5'd9; cyc(0, 0, 0);
        for (int i = 0; i < 15; i++) cyc(1, i * 3, 0);
        chk("clamp_early", {31'd0, m_tvalid}, 32'd0);
        cyc(1, 45, 0);
        chk_ch0("clamp", 0, 45);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                log_cnt = 5'($urandom_range(0, 3));
                shift   = 3'($urandom_range(0, 7));
                cyc(0, 0, 0);
            end
            m_tready = ($urandom_range(0, 3) != 0);
            cyc($urandom_range(0, 4) != 0, int'($urandom), int'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
